// File: rtl/uart_tx.sv
// 8N1 UART transmitter: one byte per accepted tx_start, LSB first, idle-high line.
// All outputs are registered alongside the state so nothing is combinational from inputs.
//
// state | meaning
// IDLE  | line high, waiting for tx_start
// START | driving the start bit (low) for one bit period
// DATA  | driving data bits LSB first, one bit period each
// STOP  | driving the stop bit (high) for one bit period
// DONE  | one-cycle tx_done pulse; tx_start here is accepted as in IDLE
module uart_tx #(
    parameter logic [15:0] CLK_PER_BIT = 16'd5208
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_start,
    input  logic [7:0] data_in,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [15:0] LAST_CNT = CLK_PER_BIT - 16'd1;

    state_t      state;
    logic [15:0] clk_counter;
    logic [2:0]  bit_index;
    logic [7:0]  shift_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            clk_counter <= 16'd0;
            bit_index   <= 3'd0;
            shift_reg   <= 8'd0;
            tx          <= 1'b1;
            tx_busy     <= 1'b0;
            tx_done     <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    clk_counter <= 16'd0;
                    if (tx_start) begin
                        shift_reg <= data_in;
                        state     <= START;
                        tx        <= 1'b0;
                        tx_busy   <= 1'b1;
                    end else begin
                        state     <= IDLE;
                        tx        <= 1'b1;
                        tx_busy   <= 1'b0;
                    end
                end
                START: begin
                    if (clk_counter == LAST_CNT) begin
                        clk_counter <= 16'd0;
                        bit_index   <= 3'd0;
                        state       <= DATA;
                        tx          <= shift_reg[0];
                    end else begin
                        clk_counter <= clk_counter + 16'd1;
                    end
                end
                DATA: begin
                    if (clk_counter == LAST_CNT) begin
                        clk_counter <= 16'd0;
                        shift_reg   <= {1'b0, shift_reg[7:1]};
                        bit_index   <= bit_index + 3'd1;
                        if (bit_index == 3'd7) begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end else begin
                            // next bit is shift_reg[1] before the shift lands
                            tx    <= shift_reg[1];
                        end
                    end else begin
                        clk_counter <= clk_counter + 16'd1;
                    end
                end
                STOP: begin
                    if (clk_counter == LAST_CNT) begin
                        clk_counter <= 16'd0;
                        state       <= DONE;
                        tx          <= 1'b1;
                        tx_busy     <= 1'b0;
                        tx_done     <= 1'b1;
                    end else begin
                        clk_counter <= clk_counter + 16'd1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    clk_counter <= 16'd0;
                    tx          <= 1'b1;
                    tx_busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: two instances (16 and 2 clocks per bit) compared every cycle
// against a frame-timeline model (cycles since accept -> expected line level).
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] tx_start = 2'b00;
    logic [7:0] data_in [2];
    logic [1:0] tx, tx_busy, tx_done;

    int checks = 0;
    int errors = 0;

    uart_tx #(.CLK_PER_BIT(16'd16)) u_dut0 (
        .clk(clk), .reset(reset), .tx_start(tx_start[0]), .data_in(data_in[0]),
        .tx(tx[0]), .tx_busy(tx_busy[0]), .tx_done(tx_done[0])
    );

    uart_tx #(.CLK_PER_BIT(16'd2)) u_dut1 (
        .clk(clk), .reset(reset), .tx_start(tx_start[1]), .data_in(data_in[1]),
        .tx(tx[1]), .tx_busy(tx_busy[1]), .tx_done(tx_done[1])
    );

    always #5 clk = ~clk;

    function automatic int nper(int i);
        return (i == 0) ? 16 : 2;
    endfunction

    // Model: whether a frame is active, cycles since its accepting edge, and the byte.
    bit         m_act [2];
    int         m_t   [2];
    logic [7:0] m_b   [2];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                m_act[i] <= 1'b0;
                m_t[i]   <= 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (m_act[i] && m_t[i] < 10 * nper(i)) begin
                    m_t[i] <= m_t[i] + 1;
                end else if (tx_start[i]) begin
                    m_act[i] <= 1'b1;
                    m_t[i]   <= 0;
                    m_b[i]   <= data_in[i];
                end else begin
                    m_act[i] <= 1'b0;
                end
            end
        end
    end

    function automatic logic exp_tx(bit act, int t, logic [7:0] b, int n);
        if (!act) return 1'b1;
        if (t < n) return 1'b0;
        if (t < 9 * n) return b[t / n - 1];
        return 1'b1;
    endfunction

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            check($sformatf("tx%0d", i), 32'(tx[i]),
                  32'(exp_tx(m_act[i], m_t[i], m_b[i], nper(i))));
            check($sformatf("busy%0d", i), 32'(tx_busy[i]),
                  32'(m_act[i] && m_t[i] < 10 * nper(i)));
            check($sformatf("done%0d", i), 32'(tx_done[i]),
                  32'(m_act[i] && m_t[i] == 10 * nper(i)));
        end
    endtask

    task automatic cycle(int n = 1);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            check_all();
        end
    endtask

    task automatic pulse(int i, logic [7:0] b);
        tx_start[i] = 1'b1;
        data_in[i]  = b;
        cycle();
        tx_start[i] = 1'b0;
    endtask

    initial begin
        data_in[0] = 8'h00;
        data_in[1] = 8'h00;
        cycle(3);
        check("rst_tx", 32'(tx), 32'h3);
        check("rst_busy", 32'(tx_busy), 32'h0);
        check("rst_done", 32'(tx_done), 32'h0);
        reset = 1'b0;
        cycle(2);

        // 0x55 at N=16 and 0xC3 at N=2
        tx_start    = 2'b11;
        data_in[0]  = 8'h55;
        data_in[1]  = 8'hC3;
        cycle();
        tx_start    = 2'b00;
        cycle(170);

        // ignored second request and mid-frame data change
        pulse(0, 8'h12);
        cycle(39);
        pulse(0, 8'h34);
        data_in[0] = 8'hFF;
        cycle(140);

        // held start: frames back to back with one idle cycle between
        tx_start   = 2'b11;
        data_in[0] = 8'h80;
        data_in[1] = 8'h80;
        cycle(500);
        tx_start   = 2'b00;
        cycle(170);

        // reset mid-frame at E0+70
        pulse(0, 8'h00);
        cycle(69);
        reset = 1'b1;
        #1;
        check("abort_tx", 32'(tx[0]), 32'h1);
        check("abort_busy", 32'(tx_busy[0]), 32'h0);
        cycle(3);
        reset = 1'b0;
        pulse(0, 8'h0F);
        cycle(170);

        // randomized traffic, occasional resets
        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < 2; i++) begin
                tx_start[i] = ($urandom_range(0, 7) == 0);
                data_in[i]  = 8'($urandom);
            end
            reset = ($urandom_range(0, 999) == 0);
            cycle();
        end
        reset    = 1'b0;
        tx_start = 2'b00;
        cycle(200);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
